// File: rtl/jtdd_rom_mux_if.sv
// SDRAM-side handshake of the ROM-fetch arbiter.
//   master : the arbiter (drives sdram_req/sdram_addr, receives ack/data)
//   slave  : the SDRAM controller
//   sdram_addr : word address of the single-word read
//   sdram_req  : level request, held until sdram_ack
//   sdram_ack  : one-cycle accept pulse
//   data_rdy   : one-cycle pulse, data_read valid
//   data_read  : read word
interface jtdd_rom_mux_if;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        data_rdy;
  logic [15:0] data_read;

  modport master (output sdram_addr, sdram_req, input sdram_ack, data_rdy, data_read);
  modport slave  (input sdram_addr, sdram_req, output sdram_ack, data_rdy, data_read);
endinterface

// File: rtl/jtdd_rom_mux.sv
// ROM-fetch arbiter for the char / scroll / object video ROM ports.
// Each client owns a one-word cache (valid, tag, word); a client whose
// cache does not match its live address is pending, and pending clients
// are served one at a time (char > scroll > object) through a single
// SDRAM read requester.
//   clk, rst_n           : clock, async active-low reset
//   char_addr/data/ok    : char ROM byte port (byte picked from cached word)
//   scr_addr/data/ok     : scroll ROM word port
//   obj_addr/data/ok     : object ROM word port
//   sdram (master)       : request/ack/data handshake to the SDRAM controller

// One cache entry. Tags are carried at a common width; narrower clients
// zero-extend their word address so every entry is the same instance.
module jtdd_rom_mux_slot #(
  parameter int TAG_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TAG_W-1:0] addr,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [15:0]      fill_data,
  output logic             hit,
  output logic [15:0]      word
);
  logic             valid;
  logic [TAG_W-1:0] tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      word  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      word  <= fill_data;
    end
  end

  assign hit = valid && (tag == addr);
endmodule

module jtdd_rom_mux #(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET  = 22'h08000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h28000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [14:0]           char_addr,
  output logic [7:0]            char_data,
  output logic                  char_ok,
  input  logic [16:0]           scr_addr,
  output logic [15:0]           scr_data,
  output logic                  scr_ok,
  input  logic [17:0]           obj_addr,
  output logic [15:0]           obj_data,
  output logic                  obj_ok,
  jtdd_rom_mux_if.master        sdram
);
  localparam int NUM_CLIENTS = 3;
  localparam int TAG_W       = 18;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  // Client index 0 = char, 1 = scroll, 2 = object; lower index wins.
  logic [NUM_CLIENTS-1:0][TAG_W-1:0] cl_addr;
  logic [NUM_CLIENTS-1:0][15:0]      cl_word;
  logic [NUM_CLIENTS-1:0][21:0]      offs;
  logic [NUM_CLIENTS-1:0]            hit;
  logic [NUM_CLIENTS-1:0]            fill;

  state_t           state, state_nx;
  logic [1:0]       win_id, cur_id;
  logic             any_miss;
  logic [TAG_W-1:0] cur_tag;
  logic [21:0]      addr_q;
  logic             load, done;

  assign offs       = {OBJ_OFFSET, SCR_OFFSET, CHAR_OFFSET};
  assign cl_addr[0] = {4'd0, char_addr[14:1]};
  assign cl_addr[1] = {1'b0, scr_addr};
  assign cl_addr[2] = obj_addr;

  generate
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_slot
      assign fill[i] = done && (cur_id == 2'(i));
      jtdd_rom_mux_slot #(.TAG_W(TAG_W)) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (cl_addr[i]),
        .fill     (fill[i]),
        .fill_tag (cur_tag),
        .fill_data(sdram.data_read),
        .hit      (hit[i]),
        .word     (cl_word[i])
      );
    end
  endgenerate

  // Fixed priority: scan from lowest priority up so the lowest index sticks.
  always_comb begin
    win_id   = 2'd0;
    any_miss = 1'b0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (!hit[i]) begin
        win_id   = 2'(i);
        any_miss = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // An ack that arrives together with its data closes the fetch at once.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (any_miss) begin
          load     = 1'b1;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram.sdram_ack) begin
          if (sdram.data_rdy) begin
            done     = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (sdram.data_rdy) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The in-flight tag is latched at issue so the fill matches what was
  // actually fetched, even if the client has moved on meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_id  <= 2'd0;
      cur_tag <= '0;
      addr_q  <= '0;
    end else if (load) begin
      cur_id  <= win_id;
      cur_tag <= cl_addr[win_id];
      addr_q  <= offs[win_id] + {4'd0, cl_addr[win_id]};
    end
  end

  // Request is a pure state decode: rises the cycle after issue, falls on
  // ack, and drops asynchronously with reset.
  assign sdram.sdram_req  = (state == WAIT_ACK);
  assign sdram.sdram_addr = addr_q;

  assign char_ok   = hit[0];
  assign scr_ok    = hit[1];
  assign obj_ok    = hit[2];
  assign char_data = char_addr[0] ? cl_word[0][15:8] : cl_word[0][7:0];
  assign scr_data  = cl_word[1];
  assign obj_data  = cl_word[2];
endmodule
